ant_update_scheduler: RTL and testbench

//  Game-loop sequencer for the single shared ant-update datapath. Once setup releases control
//  (SETUP_MODE=0), each game_tick walks ant_id 0..ANT_NUM-1 through READ -> COMPUTE -> WRITE.

---
 rtl/ant_update_scheduler.sv | 140 ++++++++++++++
 tb/tb_ant_update_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ant_update_scheduler.sv
// Sequences ants 0..ANT_NUM-1 through READ -> COMPUTE -> WRITE on every game_tick once setup releases control.
// Per ant: d+3 cycles (done d cycles after upd_start), UPD_TIMEOUT+1 on timeout; ticks during a sweep are dropped and flagged.
module ant_update_scheduler #(
   parameter int ANT_NUM      = 64,
   parameter int ANT_NUM_BITS = 6,
   parameter int UPD_TIMEOUT  = 16,
   parameter int TICK_BITS    = 16
) (
   input  logic                    Clk,
   input  logic                    RESET_SIM,
   input  logic                    SETUP_MODE,
   input  logic                    game_tick,
   output logic [ANT_NUM_BITS-1:0] ant_id,
   output logic                    ant_rd_en,
   output logic                    upd_start,
   input  logic                    upd_done,
   output logic                    ant_wr_en,
   output logic                    busy,
   output logic [TICK_BITS-1:0]    tick_count,
   output logic                    err_overrun,
   output logic                    err_timeout
);

   localparam int CNT_W = (UPD_TIMEOUT > 2) ? $clog2(UPD_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]        CNT_MAX  = CNT_W'(UPD_TIMEOUT - 1);
   localparam logic [ANT_NUM_BITS-1:0] LAST_ANT = ANT_NUM_BITS'(ANT_NUM - 1);

   typedef enum logic [2:0] {
      S_HALT,
      S_IDLE,
      S_READ,
      S_COMPUTE,
      S_WRITE
   } state_t;

   state_t                  state_q, state_d;
   logic [ANT_NUM_BITS-1:0] ant_id_q, ant_id_d;
   logic [TICK_BITS-1:0]    tick_q, tick_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    err_ovr_q, err_ovr_d;
   logic                    err_to_q, err_to_d;
   logic                    advance;
   logic                    in_sweep;

   always_comb begin
      state_d   = state_q;
      ant_id_d  = ant_id_q;
      tick_d    = tick_q;
      cnt_d     = '0;
      err_ovr_d = err_ovr_q;
      err_to_d  = err_to_q;
      advance   = 1'b0;
      in_sweep  = (state_q == S_READ) || (state_q == S_COMPUTE) || (state_q == S_WRITE);

      case (state_q)
         S_HALT: begin
            if (!SETUP_MODE) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (SETUP_MODE) begin
               state_d = S_HALT;
            end else if (game_tick) begin
               state_d  = S_READ;
               ant_id_d = '0;
            end
         end
         S_READ: begin
            state_d = S_COMPUTE;
         end
         S_COMPUTE: begin
            cnt_d = cnt_q + CNT_W'(1);
            // done outranks expiry when both land on the final cycle
            if (upd_done) begin
               state_d = S_WRITE;
            end else if (cnt_q == CNT_MAX) begin
               err_to_d = 1'b1;
               advance  = 1'b1;
            end
         end
         S_WRITE: begin
            advance = 1'b1;
         end
         default: begin
            state_d = S_HALT;
         end
      endcase

      if (advance) begin
         if (ant_id_q == LAST_ANT) begin
            state_d  = S_IDLE;
            ant_id_d = '0;
            tick_d   = tick_q + TICK_BITS'(1);
         end else begin
            state_d  = S_READ;
            ant_id_d = ant_id_q + ANT_NUM_BITS'(1);
         end
      end

      // setup reclaiming the datapath abandons the partial sweep outright
      if (in_sweep) begin
         if (SETUP_MODE) begin
            state_d  = S_HALT;
            ant_id_d = '0;
            cnt_d    = '0;
            tick_d   = tick_q;
            err_to_d = err_to_q;
         end else if (game_tick) begin
            err_ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (RESET_SIM) begin
         state_q   <= S_HALT;
         ant_id_q  <= '0;
         tick_q    <= '0;
         cnt_q     <= '0;
         err_ovr_q <= 1'b0;
         err_to_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ant_id_q  <= ant_id_d;
         tick_q    <= tick_d;
         cnt_q     <= cnt_d;
         err_ovr_q <= err_ovr_d;
         err_to_q  <= err_to_d;
      end
   end

   assign ant_id      = ant_id_q;
   assign tick_count  = tick_q;
   assign err_overrun = err_ovr_q;
   assign err_timeout = err_to_q;
   assign ant_rd_en   = (state_q == S_READ);
   assign upd_start   = (state_q == S_COMPUTE) && (cnt_q == '0);
   assign ant_wr_en   = (state_q == S_WRITE);
   assign busy        = (state_q == S_READ) || (state_q == S_COMPUTE) || (state_q == S_WRITE);

endmodule

// File: tb/tb_ant_update_scheduler.sv
// Bench for ant_update_scheduler: four ants, 4-cycle timeout, 2-bit tick counter.
module tb_ant_update_scheduler;

   logic       Clk;
   logic       RESET_SIM;
   logic       SETUP_MODE;
   logic       game_tick;
   logic [1:0] ant_id;
   logic       ant_rd_en;
   logic       upd_start;
   logic       upd_done;
   logic       ant_wr_en;
   logic       busy;
   logic [1:0] tick_count;
   logic       err_overrun;
   logic       err_timeout;

   ant_update_scheduler #(
      .ANT_NUM(4), .ANT_NUM_BITS(2), .UPD_TIMEOUT(4), .TICK_BITS(2)
   ) dut (
      .Clk(Clk), .RESET_SIM(RESET_SIM), .SETUP_MODE(SETUP_MODE), .game_tick(game_tick),
      .ant_id(ant_id), .ant_rd_en(ant_rd_en), .upd_start(upd_start), .upd_done(upd_done),
      .ant_wr_en(ant_wr_en), .busy(busy), .tick_count(tick_count),
      .err_overrun(err_overrun), .err_timeout(err_timeout)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // done delay per ant, counted from upd_start; 0 means the ant never answers
   int dly [4];

   initial begin
      int d;
      upd_done = 1'b0;
      forever begin
         @(negedge Clk);
         if (upd_start) begin
            d = dly[ant_id];
            if (d > 0) begin
               repeat (d) @(negedge Clk);
               upd_done = 1'b1;
               @(negedge Clk);
               upd_done = 1'b0;
            end
         end
      end
   end

   typedef struct {
      int d [4];
      int busy_cycles;
      int writes;
      bit timeout;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int busy_cnt = 0, rd_cnt = 0, st_cnt = 0, wr_cnt = 0;
   logic [1:0] last_rd = '0;
   bit sb_en = 1'b0;
   int exp_rd_q [$];
   int exp_wr_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic bad_evt(input string name, input int act);
      total++;
      bad++;
      $display("FAIL %s: got %0d, expected no such event", name, act);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
      if (busy) busy_cnt++;
      if (ant_rd_en) begin
         rd_cnt++;
         last_rd = ant_id;
         if (sb_en) begin
            if (exp_rd_q.size() == 0) bad_evt("rd_unexpected", ant_id);
            else chk("rd_id", ant_id, exp_rd_q.pop_front());
         end
      end
      if (upd_start) begin
         st_cnt++;
         chk("start_id_stable", ant_id, last_rd);
      end
      if (ant_wr_en) begin
         wr_cnt++;
         if (sb_en) begin
            if (exp_wr_q.size() == 0) bad_evt("wr_unexpected", ant_id);
            else chk("wr_id", ant_id, exp_wr_q.pop_front());
         end
      end
   endtask

   task automatic do_reset();
      RESET_SIM = 1'b1;
      step();
      RESET_SIM = 1'b0;
   endtask

   task automatic start_idle();
      do_reset();
      SETUP_MODE = 1'b0;
      step();
   endtask

   task automatic tick();
      game_tick = 1'b1;
      step();
      game_tick = 1'b0;
   endtask

   task automatic run_until_idle(input int max_cyc);
      int n;
      n = 0;
      while (busy && n < max_cyc) begin
         step();
         n++;
      end
      if (busy) bad_evt("sweep_never_ended", n);
   endtask

   task automatic wait_start(input int id);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (upd_start && ant_id == id[1:0]) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk("found_start", ok, 1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int b0, r0, s0, w0;
      start_idle();
      for (int a = 0; a < 4; a++) begin
         dly[a] = v.d[a];
         exp_rd_q.push_back(a);
         if (v.d[a] != 0) exp_wr_q.push_back(a);
      end
      sb_en = 1'b1;
      b0 = busy_cnt; r0 = rd_cnt; s0 = st_cnt; w0 = wr_cnt;
      tick();
      run_until_idle(100);
      sb_en = 1'b0;
      $display("vector %0d done", idx);
      chk("vec_busy_cycles", busy_cnt - b0, v.busy_cycles);
      chk("vec_reads", rd_cnt - r0, 4);
      chk("vec_starts", st_cnt - s0, 4);
      chk("vec_writes", wr_cnt - w0, v.writes);
      chk("vec_err_timeout", err_timeout, v.timeout);
      chk("vec_err_overrun", err_overrun, 0);
      chk("vec_tick_count", tick_count, 1);
      chk("vec_ant_id_after", ant_id, 0);
      chk("vec_rd_left", exp_rd_q.size(), 0);
      chk("vec_wr_left", exp_wr_q.size(), 0);
      exp_rd_q.delete();
      exp_wr_q.delete();
   endtask

   initial begin
      vec_t vecs [5];
      int w0, r0;
      bit found;

      vecs[0].d = '{2, 2, 2, 2}; vecs[0].busy_cycles = 20; vecs[0].writes = 4; vecs[0].timeout = 1'b0;
      vecs[1].d = '{2, 0, 2, 2}; vecs[1].busy_cycles = 20; vecs[1].writes = 3; vecs[1].timeout = 1'b1;
      vecs[2].d = '{1, 1, 1, 1}; vecs[2].busy_cycles = 16; vecs[2].writes = 4; vecs[2].timeout = 1'b0;
      vecs[3].d = '{3, 3, 3, 3}; vecs[3].busy_cycles = 24; vecs[3].writes = 4; vecs[3].timeout = 1'b0;
      vecs[4].d = '{1, 3, 0, 2}; vecs[4].busy_cycles = 20; vecs[4].writes = 3; vecs[4].timeout = 1'b1;

      RESET_SIM = 1'b1; SETUP_MODE = 1'b1; game_tick = 1'b0;
      for (int a = 0; a < 4; a++) dly[a] = 2;

      // reset values, and HALT ignores ticks while setup owns the datapath
      step();
      do_reset();
      chk("rst_ant_id", ant_id, 0);
      chk("rst_rd_en", ant_rd_en, 0);
      chk("rst_upd_start", upd_start, 0);
      chk("rst_wr_en", ant_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tick_count", tick_count, 0);
      chk("rst_err_overrun", err_overrun, 0);
      chk("rst_err_timeout", err_timeout, 0);
      step();
      tick();
      chk("halt_tick_busy", busy, 0);
      chk("halt_tick_rd", ant_rd_en, 0);
      chk("halt_tick_ovr", err_overrun, 0);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // reset in the middle of COMPUTE
      start_idle();
      for (int a = 0; a < 4; a++) dly[a] = 2;
      tick();
      wait_start(1);
      step();
      RESET_SIM = 1'b1;
      step();
      RESET_SIM = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_ant_id", ant_id, 0);
      chk("midrst_upd_start", upd_start, 0);
      chk("midrst_wr_en", ant_wr_en, 0);
      repeat (4) step();
      chk("midrst_idle_busy", busy, 0);
      tick();
      chk("midrst_tick_accepted", ant_rd_en, 1);
      run_until_idle(100);
      chk("midrst_tick_count", tick_count, 1);

      // second tick five cycles into a sweep
      start_idle();
      r0 = rd_cnt;
      tick();
      repeat (4) step();
      tick();
      run_until_idle(100);
      chk("ovr_flag", err_overrun, 1);
      chk("ovr_tick_count", tick_count, 1);
      chk("ovr_reads", rd_cnt - r0, 4);
      repeat (5) step();
      chk("ovr_dropped_busy", busy, 0);
      chk("ovr_tick_count_later", tick_count, 1);

      // tick arriving on the final WRITE cycle
      start_idle();
      tick();
      found = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (ant_wr_en && ant_id == 2'd3) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("lastwr_found", found, 1);
      chk("lastwr_no_ovr_yet", err_overrun, 0);
      tick();
      chk("lastwr_ovr", err_overrun, 1);
      chk("lastwr_busy", busy, 0);
      chk("lastwr_tick_count", tick_count, 1);
      repeat (3) step();
      chk("lastwr_dropped", busy, 0);

      // setup reclaims the datapath during ant 2 COMPUTE
      start_idle();
      w0 = wr_cnt;
      tick();
      wait_start(2);
      SETUP_MODE = 1'b1;
      step();
      chk("setup_busy", busy, 0);
      chk("setup_ant_id", ant_id, 0);
      chk("setup_wr_en", ant_wr_en, 0);
      repeat (4) step();
      chk("setup_writes", wr_cnt - w0, 2);
      chk("setup_tick_count", tick_count, 0);
      SETUP_MODE = 1'b0;

      // tick_count wraps modulo 4
      start_idle();
      for (int a = 0; a < 4; a++) dly[a] = 1;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] exp_tc;
         exp_tc = 2'(k + 1);
         tick();
         run_until_idle(100);
         step();
         chk("wrap_tick_count", tick_count, exp_tc);
      end
      chk("wrap_err_timeout", err_timeout, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
